// File: rtl/ula_operand_stage.sv
// ID/EX register in front of the ALU: operand forwarding from EX/MEM and MEM/WB,
// load-use stall detection, and bubble insertion on stall or branch flush.
module ula_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_control,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic              id_uses_rt,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] in_a,
    output logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              ex_valid_r;
    logic [3:0]        alu_control_r;
    logic [DATA_W-1:0] rs_data_r;
    logic [DATA_W-1:0] rt_data_r;
    logic [DATA_W-1:0] imm_r;
    logic              alu_src_r;
    logic [REG_W-1:0]  rs_r;
    logic [REG_W-1:0]  rt_r;
    logic [REG_W-1:0]  rd_r;
    logic              reg_write_r;
    logic              mem_read_r;
    logic [CNT_W-1:0]  bubble_count_r;

    logic              hazard_s;
    logic              bubble_s;
    logic              load_s;
    logic [DATA_W-1:0] fwd_a_s;
    logic [DATA_W-1:0] fwd_b_s;

    // The younger producer (EX/MEM) shadows MEM/WB; register 0 is hard-wired.
    function automatic logic [DATA_W-1:0] forward_operand(
        input logic [REG_W-1:0]  src,
        input logic [DATA_W-1:0] rf_data,
        input logic              em_we,
        input logic [REG_W-1:0]  em_rd,
        input logic [DATA_W-1:0] em_res,
        input logic              wb_we,
        input logic [REG_W-1:0]  wb_rd,
        input logic [DATA_W-1:0] wb_res
    );
        logic [DATA_W-1:0] val;
        if (em_we && (em_rd != REG_ZERO) && (em_rd == src)) begin
            val = em_res;
        end else if (wb_we && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
            val = wb_res;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Load-use hazard: the load in EX produces a register decode wants to read.
    always_comb begin
        hazard_s = 1'b0;
        if (ex_valid_r && mem_read_r && (rd_r != REG_ZERO) && id_valid) begin
            if ((rd_r == id_rs) || (id_uses_rt && (rd_r == id_rt))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = 1'b0;
            end
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Next-state selection: flush beats hold, hold beats hazard.
    always_comb begin
        bubble_s = flush | (~ex_hold & hazard_s);
        load_s   = ~flush & ~ex_hold & ~hazard_s;
    end

    // Operand forwarding on the registered source indices.
    always_comb begin
        fwd_a_s = forward_operand(rs_r, rs_data_r, exmem_reg_write, exmem_rd, exmem_result,
                                  memwb_reg_write, memwb_rd, memwb_result);
        fwd_b_s = forward_operand(rt_r, rt_data_r, exmem_reg_write, exmem_rd, exmem_result,
                                  memwb_reg_write, memwb_rd, memwb_result);
    end

    // ID/EX pipeline register and saturating bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r     <= 1'b0;
            alu_control_r  <= 4'b0000;
            rs_data_r      <= {DATA_W{1'b0}};
            rt_data_r      <= {DATA_W{1'b0}};
            imm_r          <= {DATA_W{1'b0}};
            alu_src_r      <= 1'b0;
            rs_r           <= REG_ZERO;
            rt_r           <= REG_ZERO;
            rd_r           <= REG_ZERO;
            reg_write_r    <= 1'b0;
            mem_read_r     <= 1'b0;
            bubble_count_r <= {CNT_W{1'b0}};
        end else if (bubble_s) begin
            ex_valid_r     <= 1'b0;
            alu_control_r  <= 4'b0000;
            alu_src_r      <= 1'b0;
            rs_r           <= REG_ZERO;
            rt_r           <= REG_ZERO;
            rd_r           <= REG_ZERO;
            reg_write_r    <= 1'b0;
            mem_read_r     <= 1'b0;
            bubble_count_r <= (&bubble_count_r) ? bubble_count_r : bubble_count_r + CNT_ONE;
        end else if (load_s) begin
            ex_valid_r     <= id_valid;
            alu_control_r  <= id_alu_control;
            rs_data_r      <= id_rs_data;
            rt_data_r      <= id_rt_data;
            imm_r          <= id_imm;
            alu_src_r      <= id_alu_src;
            rs_r           <= id_rs;
            rt_r           <= id_rt;
            rd_r           <= id_rd;
            reg_write_r    <= id_reg_write;
            mem_read_r     <= id_mem_read;
        end else begin
            ex_valid_r     <= ex_valid_r;
        end
    end

    assign stall_id      = (hazard_s | ex_hold) & ~flush;
    assign ex_valid      = ex_valid_r;
    assign alu_control   = alu_control_r;
    assign in_a          = fwd_a_s;
    assign in_b          = alu_src_r ? imm_r : fwd_b_s;
    assign ex_store_data = fwd_b_s;
    assign ex_rd         = rd_r;
    assign ex_reg_write  = reg_write_r & ex_valid_r;
    assign ex_mem_read   = mem_read_r & ex_valid_r;
    assign bubble_count  = bubble_count_r;

endmodule
